// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: internal baud tick, 3-sample majority vote,
// start-glitch rejection, run-time parity/stop modes, break detect, valid/ready output.
module uart_rx_os #(
  parameter int DataLength = 8,
  parameter int Oversample = 16,
  parameter int DivWidth   = 16,
  parameter int SyncStages = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx,
  input  logic [DivWidth-1:0]   i_clk_div,
  input  logic                  i_parity_en,
  input  logic                  i_parity_odd,
  input  logic                  i_two_stop,
  output logic [DataLength-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_parity_error,
  output logic                  o_frame_error,
  output logic                  o_break,
  output logic                  o_overrun,
  output logic                  o_busy
);

  localparam int OsW  = $clog2(Oversample);
  localparam int BitW = $clog2(DataLength);

  localparam logic [OsW-1:0]  OsMidLo = OsW'(Oversample / 2 - 1);
  localparam logic [OsW-1:0]  OsMid   = OsW'(Oversample / 2);
  localparam logic [OsW-1:0]  OsMidHi = OsW'(Oversample / 2 + 1);
  localparam logic [OsW-1:0]  OsLast  = OsW'(Oversample - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DataLength - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_DONE,
    S_RECOVER
  } state_t;

  state_t state, state_next;

  logic [SyncStages-1:0] sync_q;
  logic                  rxs;

  logic [DivWidth-1:0]   div_q;
  logic                  par_en_q;
  logic                  par_odd_q;
  logic                  two_stop_q;

  logic [DivWidth-1:0]   tick_cnt;
  logic [OsW-1:0]        os_cnt;
  logic                  tick;
  logic                  decide;
  logic                  bit_end;

  logic                  s_lo;
  logic                  s_mid;
  logic                  bit_val;

  logic [BitW-1:0]       bit_cnt;
  logic [DataLength-1:0] shreg;
  logic                  par_err_q;
  logic                  par_bit_q;
  logic                  frame_err_q;

  logic                  start_entry;
  logic                  is_break;
  logic                  handshake;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], i_rx};
    end
  end

  assign rxs         = sync_q[SyncStages-1];
  assign start_entry = (state == S_IDLE) && !rxs;
  assign o_busy      = (state != S_IDLE);

  // Frame configuration is captured on the falling start edge so mid-frame changes cannot corrupt it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else if (start_entry) begin
      div_q      <= i_clk_div;
      par_en_q   <= i_parity_en;
      par_odd_q  <= i_parity_odd;
      two_stop_q <= i_two_stop;
    end
  end

  assign tick    = (state != S_IDLE) && (tick_cnt == div_q);
  assign decide  = tick && (os_cnt == OsMidHi);
  assign bit_end = tick && (os_cnt == OsLast);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tick_cnt <= '0;
      os_cnt   <= '0;
    end else if (state == S_IDLE) begin
      tick_cnt <= '0;
      os_cnt   <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      os_cnt   <= (os_cnt == OsLast) ? '0 : os_cnt + OsW'(1);
    end else begin
      tick_cnt <= tick_cnt + DivWidth'(1);
    end
  end

  // The third vote is the live sample taken on the decision tick itself.
  assign bit_val = (s_lo & s_mid) | (s_lo & rxs) | (s_mid & rxs);

  assign is_break = (state == S_STOP1) && decide && !bit_val &&
                    (shreg == '0) && (!par_en_q || !par_bit_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!rxs) state_next = S_START;
      end
      S_START: begin
        if (decide && bit_val) state_next = S_IDLE;
        else if (bit_end)      state_next = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_cnt == BitLast)) state_next = par_en_q ? S_PARITY : S_STOP1;
      end
      S_PARITY: begin
        if (bit_end) state_next = S_STOP1;
      end
      S_STOP1: begin
        if (is_break)                  state_next = S_RECOVER;
        else if (two_stop_q && bit_end) state_next = S_STOP2;
        else if (!two_stop_q && decide) state_next = S_DONE;
      end
      S_STOP2: begin
        if (decide) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = rxs ? S_IDLE : S_RECOVER;
      end
      S_RECOVER: begin
        if (rxs) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s_lo        <= 1'b0;
      s_mid       <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_err_q   <= 1'b0;
      par_bit_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (start_entry) begin
        bit_cnt     <= '0;
        shreg       <= '0;
        par_err_q   <= 1'b0;
        par_bit_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end
      if (tick && (os_cnt == OsMidLo)) s_lo  <= rxs;
      if (tick && (os_cnt == OsMid))   s_mid <= rxs;
      if (decide) begin
        case (state)
          S_DATA:   shreg <= {bit_val, shreg[DataLength-1:1]};
          S_PARITY: begin
            par_err_q <= (^shreg) ^ bit_val ^ par_odd_q;
            par_bit_q <= bit_val;
          end
          S_STOP1:  frame_err_q <= !bit_val;
          S_STOP2:  frame_err_q <= frame_err_q | !bit_val;
          default:  ;
        endcase
      end
      if (bit_end && (state == S_DATA) && (bit_cnt != BitLast)) begin
        bit_cnt <= bit_cnt + BitW'(1);
      end
    end
  end

  assign handshake = o_valid && i_ready;

  // A word finishing while the previous one is still unaccepted is dropped and flagged as overrun.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data         <= '0;
      o_valid        <= 1'b0;
      o_parity_error <= 1'b0;
      o_frame_error  <= 1'b0;
      o_overrun      <= 1'b0;
      o_break        <= 1'b0;
    end else begin
      o_break <= is_break;
      if (state == S_DONE) begin
        if (!o_valid || i_ready) begin
          o_data         <= shreg;
          o_parity_error <= par_err_q;
          o_frame_error  <= frame_err_q;
          o_valid        <= 1'b1;
          if (handshake) o_overrun <= 1'b0;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (handshake) begin
        o_valid   <= 1'b0;
        o_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed scenarios plus randomized frames
// scored against a frame-level model of what each transmitted frame must produce.
module tb_uart_rx_os;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [15:0] clk_div;
  logic        parity_en;
  logic        parity_odd;
  logic        two_stop;
  logic        ready;
  logic [7:0]  data_out;
  logic        valid;
  logic        parity_error;
  logic        frame_error;
  logic        brk;
  logic        overrun;
  logic        busy;

  uart_rx_os #(
    .DataLength(8),
    .Oversample(16),
    .DivWidth(16),
    .SyncStages(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rx(rx),
    .i_clk_div(clk_div),
    .i_parity_en(parity_en),
    .i_parity_odd(parity_odd),
    .i_two_stop(two_stop),
    .o_data(data_out),
    .o_valid(valid),
    .i_ready(ready),
    .o_parity_error(parity_error),
    .o_frame_error(frame_error),
    .o_break(brk),
    .o_overrun(overrun),
    .o_busy(busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    time        t0;
    int         lat_lo;
    int         lat_hi;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  exp_t cur;
  int   brk_expected = 0;
  logic pending = 1'b0;
  logic exp_overrun = 1'b0;

  int   cfg_div = 3;
  logic cfg_pen = 1'b0;
  logic cfg_odd = 1'b0;
  logic cfg_two = 1'b0;

  logic prev_valid = 1'b0;
  logic prev_hs = 1'b0;
  logic prev_brk = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic driveConfig();
    clk_div    = 16'(cfg_div);
    parity_en  = cfg_pen;
    parity_odd = cfg_odd;
    two_stop   = cfg_two;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      waitCycles(1);
      n++;
    end
    checkOutput("busy_release", 32'(busy), 32'd0);
  endtask

  // Transmit one frame and record in the model what it must produce.
  task automatic applyStimulus(input logic [7:0] data, input logic pflip,
                               input logic stop1, input logic stop2);
    int   bclk;
    int   nbits;
    logic pbit;
    logic is_brk;
    exp_t e;
    bclk   = (cfg_div + 1) * 16;
    nbits  = 10 + (cfg_pen ? 1 : 0) + (cfg_two ? 1 : 0);
    pbit   = (^data) ^ cfg_odd ^ pflip;
    is_brk = (data == 8'h00) && (!cfg_pen || !pbit) && !stop1;
    if (is_brk) begin
      brk_expected++;
    end else if (pending) begin
      exp_overrun = 1'b1;
    end else begin
      e.data   = data;
      e.perr   = cfg_pen && (((^data) ^ pbit ^ cfg_odd) == 1'b1);
      e.ferr   = !stop1 || (cfg_two && !stop2);
      e.t0     = $time;
      e.lat_lo = bclk * (nbits - 1) + bclk / 2;
      e.lat_hi = bclk * nbits;
      exp_q.push_back(e);
      pending = 1'b1;
    end
    rx = 1'b0;
    waitCycles(6);
    clk_div    = 16'($urandom_range(0, 9));
    parity_en  = ~cfg_pen;
    parity_odd = ~cfg_odd;
    two_stop   = ~cfg_two;
    waitCycles(bclk - 6);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      waitCycles(bclk);
    end
    if (cfg_pen) begin
      rx = pbit;
      waitCycles(bclk);
    end
    rx = stop1;
    waitCycles(bclk);
    if (cfg_two) begin
      rx = stop2;
      waitCycles(bclk);
    end
    driveConfig();
    rx = 1'b1;
    waitCycles(2 * bclk);
    waitIdle(4 * bclk);
    checkOutput("valid_after_frame", 32'(valid), 32'(pending));
    checkOutput("overrun_after_frame", 32'(overrun), 32'(exp_overrun));
  endtask

  task automatic doHandshake();
    ready = 1'b1;
    waitCycles(1);
    ready = 1'b0;
    pending = 1'b0;
    exp_overrun = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    rx = 1'b1;
    ready = 1'b0;
    exp_q.delete();
    pending = 1'b0;
    exp_overrun = 1'b0;
    brk_expected = 0;
    waitCycles(3);
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_data", 32'(data_out), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
    checkOutput("reset_break", 32'(brk), 32'd0);
    checkOutput("reset_perr", 32'(parity_error), 32'd0);
    checkOutput("reset_ferr", 32'(frame_error), 32'd0);
    rst = 1'b0;
    waitCycles(4);
  endtask

  // Every cycle: new words must match the model in order, held words must not change, breaks must be expected.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      prev_brk   = 1'b0;
    end else begin
      if (valid) begin
        if (!prev_valid || prev_hs) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_word: got data 0x%0h, expected no word at %0t", data_out, $time);
            cur.data = data_out;
            cur.perr = parity_error;
            cur.ferr = frame_error;
          end else begin
            int lat;
            cur = exp_q.pop_front();
            lat = int'(($time - cur.t0) / 10);
            tests++;
            if (lat < cur.lat_lo || lat > cur.lat_hi) begin
              fails++;
              $display("[TB] FAIL valid_latency: got %0d clk, expected %0d..%0d clk", lat, cur.lat_lo, cur.lat_hi);
            end
          end
        end
        checkOutput("word_data", 32'(data_out), 32'(cur.data));
        checkOutput("word_perr", 32'(parity_error), 32'(cur.perr));
        checkOutput("word_ferr", 32'(frame_error), 32'(cur.ferr));
      end
      if (brk) begin
        tests++;
        if (brk_expected == 0 || prev_brk) begin
          fails++;
          $display("[TB] FAIL break_pulse: got pulse (prev=%0d), expected %0d pending breaks", prev_brk, brk_expected);
        end else begin
          brk_expected--;
        end
      end
      prev_valid = valid;
      prev_hs    = valid && ready;
      prev_brk   = brk;
    end
  end

  initial begin
    logic [7:0] d;
    logic       pf;
    logic       s1;
    logic       s2;
    rst = 1'b1;
    rx = 1'b1;
    ready = 1'b0;
    driveConfig();
    doReset();

    // 8N1 0xA5 held without ready, then accepted.
    cfg_div = 3; cfg_pen = 1'b0; cfg_odd = 1'b0; cfg_two = 1'b0;
    driveConfig();
    applyStimulus(8'hA5, 1'b0, 1'b1, 1'b1);
    waitCycles(500);
    checkOutput("a5_valid_held", 32'(valid), 32'd1);
    checkOutput("a5_data", 32'(data_out), 32'hA5);
    checkOutput("a5_no_errors", 32'({parity_error, frame_error}), 32'd0);
    doHandshake();
    checkOutput("a5_valid_cleared", 32'(valid), 32'd0);

    // 8E1 0x3C: wrong parity bit 1, then correct parity bit 0.
    cfg_pen = 1'b1;
    driveConfig();
    applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1);
    checkOutput("3c_data", 32'(data_out), 32'h3C);
    checkOutput("3c_perr_set", 32'(parity_error), 32'd1);
    doHandshake();
    applyStimulus(8'h3C, 1'b0, 1'b1, 1'b1);
    checkOutput("3c_perr_clear", 32'(parity_error), 32'd0);
    doHandshake();

    // Short low glitch must be rejected.
    cfg_pen = 1'b0;
    driveConfig();
    rx = 1'b0;
    waitCycles(20);
    rx = 1'b1;
    waitIdle(64);
    checkOutput("glitch_no_valid", 32'(valid), 32'd0);
    applyStimulus(8'h55, 1'b0, 1'b1, 1'b1);
    checkOutput("post_glitch_data", 32'(data_out), 32'h55);
    doHandshake();

    // Stop bit low gives frame error; next frame clean.
    applyStimulus(8'h0F, 1'b0, 1'b0, 1'b1);
    checkOutput("0f_ferr_set", 32'(frame_error), 32'd1);
    doHandshake();
    applyStimulus(8'h0F, 1'b0, 1'b1, 1'b1);
    checkOutput("0f_ferr_clear", 32'(frame_error), 32'd0);
    doHandshake();

    // Line held low for 30 bit times is a break.
    brk_expected = 1;
    rx = 1'b0;
    waitCycles(30 * 64);
    checkOutput("break_busy_held", 32'(busy), 32'd1);
    checkOutput("break_pulse_seen", 32'(brk_expected), 32'd0);
    checkOutput("break_no_valid", 32'(valid), 32'd0);
    rx = 1'b1;
    waitIdle(64);
    applyStimulus(8'h81, 1'b0, 1'b1, 1'b1);
    checkOutput("post_break_data", 32'(data_out), 32'h81);
    doHandshake();

    // Second frame while first is unaccepted is dropped.
    applyStimulus(8'h11, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'h22, 1'b0, 1'b1, 1'b1);
    checkOutput("ovr_data_kept", 32'(data_out), 32'h11);
    checkOutput("ovr_flag", 32'(overrun), 32'd1);
    doHandshake();
    checkOutput("ovr_valid_cleared", 32'(valid), 32'd0);
    checkOutput("ovr_flag_cleared", 32'(overrun), 32'd0);

    // Reset in the middle of a frame discards it.
    rx = 1'b0;
    waitCycles(3 * 64);
    doReset();
    driveConfig();
    applyStimulus(8'hC3, 1'b0, 1'b1, 1'b1);
    checkOutput("post_reset_data", 32'(data_out), 32'hC3);
    doHandshake();

    // Randomized frames with random modes, errors and consumer behaviour.
    for (int f = 0; f < 30; f++) begin
      cfg_div = int'($urandom_range(1, 5));
      cfg_pen = 1'($urandom_range(0, 1));
      cfg_odd = 1'($urandom_range(0, 1));
      cfg_two = 1'($urandom_range(0, 1));
      driveConfig();
      waitCycles(2);
      d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      pf = ($urandom_range(0, 3) == 0);
      s1 = ($urandom_range(0, 5) != 0);
      s2 = ($urandom_range(0, 5) != 0);
      applyStimulus(d, pf, s1, s2);
      if (pending && $urandom_range(0, 3) != 0) begin
        waitCycles(int'($urandom_range(0, 20)));
        doHandshake();
      end
    end
    if (pending) doHandshake();
    waitCycles(4);
    checkOutput("final_breaks_consumed", 32'(brk_expected), 32'd0);
    checkOutput("final_queue_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("final_valid", 32'(valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
